apb_cmd_master: RTL and testbench

- Single-outstanding APB initiator; converts a valid/ready command stream into APB3 SETUP/ACCESS transfers.
- Drives peripheral slaves such as the GPIO controller (psel/penable/paddr/pwrite/pwdata; samples prdata/pready/pslverr).
- Returns a response record per command on a valid/ready response channel.
- Includes a pready-wait timeout so a hung slave cannot stall the command source.

---
 rtl/apb_cmd_master.sv | 82 ++++++++
 tb/tb_apb_cmd_master.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB3 initiator bridging a valid/ready command stream to SETUP/ACCESS transfers
module apb_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
    logic [1:0]  state;
    logic [15:0] cnt;
    assign cmd_ready = (state == IDLE) && !preset;
    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    paddr  <= cmd_addr;
                    pwrite <= cmd_write;
                    pwdata <= cmd_wdata;
                    psel   <= 1'b1;
                    state  <= SETUP;
                end
                SETUP: begin
                    penable <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: if (pready || cnt == CNT_LAST) begin
                    // pready wins over the timeout in the final allowed cycle
                    rsp_rdata   <= (pready && !pwrite) ? prdata : '0;
                    rsp_err     <= pready ? pslverr : 1'b1;
                    rsp_timeout <= !pready;
                    rsp_valid   <= 1'b1;
                    psel        <= 1'b0;
                    penable     <= 1'b0;
                    state       <= RESP;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed scenario bench for apb_cmd_master with TIMEOUT=4
module tb_apb_cmd_master;
    logic        pclk = 1'b0;
    logic        preset, cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic [66:0] pbus;
    logic [34:0] rsp;
    int errors = 0;
    int checks = 0;
    assign pbus = {psel, penable, pwrite, paddr, pwdata};
    assign rsp  = {rsp_valid, rsp_err, rsp_timeout, rsp_rdata};
    always #5 pclk = ~pclk;
    apb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
    endtask
    task automatic test_reset();
        preset = 1'b1;
        tick();
        tick();
        checks++;
        if (pbus !== 67'd0) begin errors++; $display("FAIL reset_pbus: got %h want 0", pbus); end
        checks++;
        if (rsp !== 35'd0) begin errors++; $display("FAIL reset_rsp: got %h want 0", rsp); end
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        preset = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
    endtask
    task automatic test_zero_wait_write();
        pready = 1'b1;
        issue(32'h4, 1'b1, 32'hA5);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (pbus !== {3'b101, 32'h4, 32'hA5}) begin errors++; $display("FAIL zw_setup: got %h want %h", pbus, {3'b101, 32'h4, 32'hA5}); end
        tick();
        checks++;
        if (pbus !== {3'b111, 32'h4, 32'hA5} || rsp_valid !== 1'b0) begin errors++; $display("FAIL zw_access: got %h/%b want %h/0", pbus, rsp_valid, {3'b111, 32'h4, 32'hA5}); end
        tick();
        checks++;
        if (rsp !== {3'b100, 32'h0} || psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL zw_resp: got %h psel=%b pen=%b want %h", rsp, psel, penable, {3'b100, 32'h0}); end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL zw_idle: got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready); end
    endtask
    task automatic test_wait_read();
        pready  = 1'b0;
        pslverr = 1'b1;
        prdata  = 32'hDEAD_BEEF;
        issue(32'h50, 1'b0, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                pready  = 1'b1;
                pslverr = 1'b0;
                prdata  = 32'h3C;
            end
            checks++;
            if (pbus !== {3'b110, 32'h50, 32'h0} || rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_access%0d: got %h/%b want %h/0", i, pbus, rsp_valid, {3'b110, 32'h50, 32'h0}); end
            tick();
        end
        checks++;
        if (rsp !== {3'b100, 32'h3C} || psel !== 1'b0) begin errors++; $display("FAIL wr_resp: got %h psel=%b want %h", rsp, psel, {3'b100, 32'h3C}); end
        prdata = 32'h0;
        tick();
    endtask
    task automatic test_slave_err();
        pready  = 1'b1;
        pslverr = 1'b1;
        issue(32'h8, 1'b1, 32'h11);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (rsp !== {3'b110, 32'h0}) begin errors++; $display("FAIL slverr_resp: got %h want %h", rsp, {3'b110, 32'h0}); end
        pslverr = 1'b0;
        tick();
    endtask
    task automatic test_timeout();
        pready = 1'b0;
        prdata = 32'hFFFF_FFFF;
        issue(32'h10, 1'b0, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({psel, penable, rsp_valid} !== 3'b110) begin errors++; $display("FAIL to_access%0d: got %b want 110", i, {psel, penable, rsp_valid}); end
            tick();
        end
        checks++;
        if (rsp !== {3'b111, 32'h0} || psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL to_resp: got %h psel=%b pen=%b want %h", rsp, psel, penable, {3'b111, 32'h0}); end
        pready = 1'b1;
        prdata = 32'h0;
        tick();
    endtask
    task automatic test_back_to_back();
        rsp_ready = 1'b0;
        pready    = 1'b1;
        issue(32'h20, 1'b1, 32'h55);
        tick();
        issue(32'h24, 1'b1, 32'h66);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp !== {3'b100, 32'h0} || cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got %h ready=%b want %h/0", i, rsp, cmd_ready, {3'b100, 32'h0}); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || pbus !== {3'b001, 32'h20, 32'h55}) begin errors++; $display("FAIL bp_idle: got ready=%b valid=%b pbus=%h want 1/0/%h", cmd_ready, rsp_valid, pbus, {3'b001, 32'h20, 32'h55}); end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (pbus !== {3'b101, 32'h24, 32'h66}) begin errors++; $display("FAIL bp_second: got %h want %h", pbus, {3'b101, 32'h24, 32'h66}); end
        tick();
        tick();
        tick();
    endtask
    task automatic test_reset_mid();
        pready = 1'b0;
        issue(32'h30, 1'b1, 32'h77);
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL rm_access: got %b want 11", {psel, penable}); end
        preset = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_in_reset: got %b want 0", cmd_ready); end
        tick();
        preset = 1'b0;
        #1;
        checks++;
        if (pbus !== 67'd0 || rsp !== 35'd0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_after: got pbus=%h rsp=%h ready=%b want 0/0/1", pbus, rsp, cmd_ready); end
        pready = 1'b1;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || psel !== 1'b0) begin errors++; $display("FAIL rm_no_rsp: got valid=%b psel=%b want 0/0", rsp_valid, psel); end
    endtask
    initial begin
        preset = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
        rsp_ready = 1'b1; prdata = '0; pready = 1'b1; pslverr = 1'b0;
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slave_err();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
